irq_pending_latch: RTL and testbench

//  Upstream request-capture stage for the 4-to-2 priority encoder. Samples N request lines
//  and latches them into sticky pending bits, each captured on a level or a rising edge.

---
 rtl/irq_pending_latch_pkg.sv | 12 +
 rtl/irq_pending_latch_edge_detect.sv | 20 ++
 rtl/irq_pending_latch.sv | 99 +++++++++
 tb/tb_irq_pending_latch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pending_latch_pkg.sv
// Shared types for the interrupt pending latch: FSM encoding and default source count.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLDOFF = 2'd2
   } irq_state_t;

   localparam int N_SRC_DEF = 4;

endpackage

// File: rtl/irq_pending_latch_edge_detect.sv
// Rising-edge detector: remembers last cycle's request lines and flags 0->1 transitions.
module edge_detect #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic [W-1:0] src,
   output logic [W-1:0] rise
);

   logic [W-1:0] src_prev_d, src_prev_q;

   // Loading src every cycle, reset included, means a line already high at
   // reset release never looks like a fresh edge.
   always_comb src_prev_d = src;

   always_ff @(posedge clk) src_prev_q <= src_prev_d;

   assign rise = src & ~src_prev_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky request capture with mask, irq handshake FSM, single-bit ack clear and overflow flags.
module irq_pending_latch
   import irq_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF,
   parameter int IDX_W = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src,
   input  logic             edge_mode,
   input  logic             mask_wr,
   input  logic [N_SRC-1:0] mask_wdata,
   output logic [N_SRC-1:0] pend_y,
   output logic [N_SRC-1:0] pend_raw,
   output logic             irq,
   input  logic             irq_ack,
   input  logic [IDX_W-1:0] ack_idx,
   output logic             ack_err,
   output logic [N_SRC-1:0] ovf,
   input  logic             ovf_clr
);

   logic [N_SRC-1:0] pending_d, pending_q;
   logic [N_SRC-1:0] mask_d, mask_q;
   logic [N_SRC-1:0] ovf_d, ovf_q;
   logic             irq_d, irq_q;
   logic             ack_err_d, ack_err_q;
   irq_state_t       state_d, state_q;

   logic [N_SRC-1:0] rise, set, clr;
   logic             ack_vld, ack_pend;

   edge_detect #(.W(N_SRC)) u_edge (
      .clk  (clk),
      .src  (src),
      .rise (rise)
   );

   assign set    = edge_mode ? rise : src;
   assign pend_y = pending_q & ~mask_q;

   assign ack_vld = (state_q == ASSERT) & irq_ack;

   // Indices beyond N_SRC never match, so they read as not pending.
   always_comb begin
      ack_pend = 1'b0;
      clr      = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (ack_idx == IDX_W'(i)) begin
            ack_pend = pend_y[i];
            clr[i]   = ack_vld & pend_y[i];
         end
      end
   end

   always_comb begin
      pending_d = set | (pending_q & ~clr);
      mask_d    = mask_wr ? mask_wdata : mask_q;
      ovf_d     = ovf_clr ? '0 : (ovf_q | ({N_SRC{edge_mode}} & set & pending_q & ~clr));
      ack_err_d = ack_vld & ~ack_pend;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|pend_y) state_d = ASSERT;
         ASSERT:  if (irq_ack) state_d = HOLDOFF;
                  else if (~|pend_y) state_d = IDLE;
         HOLDOFF: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      irq_d = (state_d == ASSERT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         mask_q    <= '0;
         ovf_q     <= '0;
         irq_q     <= 1'b0;
         ack_err_q <= 1'b0;
         state_q   <= IDLE;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         ovf_q     <= ovf_d;
         irq_q     <= irq_d;
         ack_err_q <= ack_err_d;
         state_q   <= state_d;
      end
   end

   assign pend_raw = pending_q;
   assign irq      = irq_q;
   assign ack_err  = ack_err_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed scenarios with literal expectations, then random traffic vs a reference model.
module tb_irq_pending_latch;

   localparam int N = 4;
   localparam int W = 2;
   localparam int M_IDLE = 0, M_ASSERT = 1, M_HOLD = 2;

   logic         clk = 1'b0;
   logic         rst, edge_mode, mask_wr, irq_ack, ovf_clr;
   logic [N-1:0] src, mask_wdata, pend_y, pend_raw, ovf;
   logic [W-1:0] ack_idx;
   logic         irq, ack_err;

   int n_chk = 0;
   int n_pass = 0;

   irq_pending_latch #(.N_SRC(N), .IDX_W(W)) dut (
      .clk(clk), .rst(rst), .src(src), .edge_mode(edge_mode),
      .mask_wr(mask_wr), .mask_wdata(mask_wdata), .pend_y(pend_y),
      .pend_raw(pend_raw), .irq(irq), .irq_ack(irq_ack), .ack_idx(ack_idx),
      .ack_err(ack_err), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: what each output must be, stepped once per clock.
   typedef struct {
      logic [N-1:0] pend, mask, ovf, prev;
      int           st;
      logic         irq, err;
   } mdl_t;

   mdl_t m;
   logic m_valid = 1'b0;

   function automatic mdl_t step(mdl_t s);
      mdl_t   n;
      logic [N-1:0] visible;
      bit     acking, hit;
      n = s;
      n.prev = src;
      if (rst) begin
         n.pend = '0; n.mask = '0; n.ovf = '0; n.st = M_IDLE; n.irq = 0; n.err = 0;
         return n;
      end
      visible = s.pend & ~s.mask;
      acking  = (s.st == M_ASSERT) && irq_ack;
      hit     = acking && (int'(ack_idx) < N) && visible[ack_idx];
      for (int i = 0; i < N; i++) begin
         bit req, gone;
         req  = edge_mode ? (src[i] && !s.prev[i]) : src[i];
         gone = hit && (int'(ack_idx) == i);
         if (edge_mode && req && s.pend[i] && !gone) n.ovf[i] = 1'b1;
         if (req) n.pend[i] = 1'b1;
         else if (gone) n.pend[i] = 1'b0;
      end
      if (ovf_clr) n.ovf = '0;
      if (mask_wr) n.mask = mask_wdata;
      case (s.st)
         M_IDLE:   n.st = (visible != 0) ? M_ASSERT : M_IDLE;
         M_ASSERT: n.st = irq_ack ? M_HOLD : ((visible == 0) ? M_IDLE : M_ASSERT);
         default:  n.st = M_IDLE;
      endcase
      n.irq = (n.st == M_ASSERT);
      n.err = acking && !hit;
      return n;
   endfunction

   always @(posedge clk) begin
      m <= step(m);
      if (rst) m_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("pend_raw", 16'(pend_raw), 16'(m.pend));
         chk("pend_y",   16'(pend_y),   16'(m.pend & ~m.mask));
         chk("irq",      16'(irq),      16'(m.irq));
         chk("ack_err",  16'(ack_err),  16'(m.err));
         chk("ovf",      16'(ovf),      16'(m.ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; src = '0; tick(); rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; src = '0; edge_mode = 1'b1; mask_wr = 1'b0; mask_wdata = '0;
      irq_ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
      tick(); tick();
      chk("rst_pend", 16'(pend_raw), 16'h0);
      chk("rst_irq",  16'(irq),      16'h0);
      chk("rst_ovf",  16'(ovf),      16'h0);
      chk("rst_err",  16'(ack_err),  16'h0);
      rst = 1'b0; tick();

      // single edge -> pend next cycle -> irq the cycle after -> ack
      src = 4'b0100; tick();
      chk("t1_pend", 16'(pend_raw), 16'h4);
      chk("t1_irq0", 16'(irq), 16'h0);
      tick();
      chk("t1_irq1", 16'(irq), 16'h1);
      irq_ack = 1'b1; ack_idx = 2'd2; tick();
      chk("t1_clr", 16'(pend_raw), 16'h0);
      chk("t1_hold", 16'(irq), 16'h0);
      irq_ack = 1'b0; tick(); tick();
      chk("t1_idle", 16'(irq), 16'h0);

      // two sources, serviced one at a time
      src = '0; tick(); src = 4'b1010; tick();
      chk("t2_py", 16'(pend_y), 16'ha);
      tick();
      chk("t2_irq", 16'(irq), 16'h1);
      irq_ack = 1'b1; ack_idx = 2'd3; tick();
      chk("t2_py3", 16'(pend_y), 16'h2);
      chk("t2_hold", 16'(irq), 16'h0);
      irq_ack = 1'b0; tick(); tick();
      chk("t2_reirq", 16'(irq), 16'h1);
      irq_ack = 1'b1; ack_idx = 2'd1; tick();
      chk("t2_py1", 16'(pend_y), 16'h0);
      irq_ack = 1'b0; tick(); tick();
      chk("t2_quiet", 16'(irq), 16'h0);

      // set beats clear; repeat edge on pending bit flags overflow
      src = '0; tick(); src = 4'b0001; tick(); tick();
      chk("t3_irq", 16'(irq), 16'h1);
      src = '0; tick();
      src = 4'b0001; irq_ack = 1'b1; ack_idx = 2'd0; tick();
      chk("t3_keep", 16'(pend_raw), 16'h1);
      chk("t3_noovf", 16'(ovf), 16'h0);
      irq_ack = 1'b0; src = '0; tick(); src = 4'b0001; tick();
      chk("t3_ovf", 16'(ovf), 16'h1);
      tick();
      chk("t3_sticky", 16'(ovf), 16'h1);
      ovf_clr = 1'b1; tick();
      chk("t3_ovfclr", 16'(ovf), 16'h0);
      ovf_clr = 1'b0;

      // masking withdraws the request, unmasking restores it
      do_reset(); src = 4'b0001; tick(); tick();
      chk("t4_irq", 16'(irq), 16'h1);
      mask_wr = 1'b1; mask_wdata = 4'b0001; tick();
      chk("t4_py0", 16'(pend_y), 16'h0);
      chk("t4_irqstill", 16'(irq), 16'h1);
      mask_wr = 1'b0; tick();
      chk("t4_wd", 16'(irq), 16'h0);
      chk("t4_raw", 16'(pend_raw), 16'h1);
      mask_wr = 1'b1; mask_wdata = '0; tick();
      chk("t4_unm_irq0", 16'(irq), 16'h0);
      chk("t4_unm_py", 16'(pend_y), 16'h1);
      mask_wr = 1'b0; tick();
      chk("t4_reirq", 16'(irq), 16'h1);

      // bad ack index; ack outside ASSERT
      irq_ack = 1'b1; ack_idx = 2'd3; tick();
      chk("t5_err", 16'(ack_err), 16'h1);
      chk("t5_raw", 16'(pend_raw), 16'h1);
      chk("t5_hold", 16'(irq), 16'h0);
      irq_ack = 1'b0; tick();
      chk("t5_errpulse", 16'(ack_err), 16'h0);
      do_reset(); src = 4'b0001; mask_wr = 1'b1; mask_wdata = 4'hf; tick();
      mask_wr = 1'b0; irq_ack = 1'b1; ack_idx = 2'd0; tick();
      chk("t5_idle_raw", 16'(pend_raw), 16'h1);
      chk("t5_idle_err", 16'(ack_err), 16'h0);
      chk("t5_idle_irq", 16'(irq), 16'h0);
      irq_ack = 1'b0;

      // level mode, then reset mid-operation with lines held high
      do_reset(); edge_mode = 1'b0; src = 4'b0010; tick();
      chk("t6_pend", 16'(pend_raw), 16'h2);
      tick();
      chk("t6_irq", 16'(irq), 16'h1);
      irq_ack = 1'b1; ack_idx = 2'd1; tick();
      chk("t6_reset_bit", 16'(pend_raw), 16'h2);
      chk("t6_hold", 16'(irq), 16'h0);
      chk("t6_noerr", 16'(ack_err), 16'h0);
      irq_ack = 1'b0; tick(); tick();
      chk("t6_reirq", 16'(irq), 16'h1);
      src = 4'hf; tick();
      chk("t6_all", 16'(pend_raw), 16'hf);
      rst = 1'b1; edge_mode = 1'b1; tick();
      chk("t6_rst_pend", 16'(pend_raw), 16'h0);
      chk("t6_rst_irq", 16'(irq), 16'h0);
      chk("t6_rst_ovf", 16'(ovf), 16'h0);
      chk("t6_rst_err", 16'(ack_err), 16'h0);
      rst = 1'b0; tick();
      chk("t6_nocap", 16'(pend_raw), 16'h0);
      tick();
      chk("t6_noirq", 16'(irq), 16'h0);

      // random traffic, checked every cycle by the model compare
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 99) == 0) edge_mode = ~edge_mode;
         src        = src ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         mask_wr    = ($urandom_range(0, 19) == 0);
         mask_wdata = 4'($urandom_range(0, 15));
         irq_ack    = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         ack_idx    = 2'($urandom_range(0, 3));
         ovf_clr    = ($urandom_range(0, 29) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
